// File: rtl/spi_pkg.sv
// Shared types and edge-polarity helpers for the oversampled SPI slave.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_state_t;

    function automatic logic leading_is_rise(input int unsigned cpol);
        return (cpol == 0);
    endfunction

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
    function automatic logic sample_is_rise(input int unsigned cpol, input int unsigned cpha);
        return leading_is_rise(cpol) ^ (cpha != 0);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with level and edge strobes.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_sync.sv
// Full-duplex SPI slave oversampled in the CLK domain, all four SPI modes.
// Define SPI_SLAVE_BURST_EN to stream back-to-back words under one CSbar.
module spi_slave_sync #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SCK,
    input  logic             CSbar,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             TX_UNDERRUN,
    output logic             FRAME_ERR,
    output logic             BUSY
);
    import spi_pkg::*;

    localparam int unsigned      CNT_W       = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(WIDTH);
    localparam logic             SAMPLE_RISE = sample_is_rise(CPOL, CPHA);

    logic w_sck_level, w_sck_rise, w_sck_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_sample_edge, w_shift_edge, w_word_done;
    logic [WIDTH-1:0] w_rx_word;
    logic w_unused;

    spi_state_t       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift_out;
    logic [WIDTH-1:0] r_shift_in;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_first_edge;
    logic             r_reload;
    logic             r_miso_oe;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_tx_underrun;
    logic             r_frame_err;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sck (
        .i_clk(CLK), .i_rst(RST), .i_async(SCK),
        .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(CLK), .i_rst(RST), .i_async(CSbar),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(CLK), .i_rst(RST), .i_async(MOSI),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sck_level, w_cs_level, w_mosi_rise, w_mosi_fall, r_shift_in[WIDTH-1]};

    assign w_sample_edge = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift_edge  = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
    assign w_rx_word     = {r_shift_in[WIDTH-2:0], w_mosi};
    assign w_word_done   = (r_state == SHIFT) && w_sample_edge && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_shift_out   <= '0;
            r_shift_in    <= '0;
            r_bit_cnt     <= '0;
            r_first_edge  <= 1'b0;
            r_reload      <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;

            // A load only clears the full flag when it consumed a word, so a
            // same-cycle capture into an empty register is never lost.
            if (TX_VALID && !r_hold_full) begin
                r_hold      <= TX_DATA;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        if (r_hold_full) begin
                            r_shift_out <= r_hold;
                            r_hold_full <= 1'b0;
                        end else begin
                            r_shift_out   <= '0;
                            r_tx_underrun <= 1'b1;
                        end
                        r_bit_cnt    <= '0;
                        r_first_edge <= 1'b1;
                        r_reload     <= 1'b0;
                        r_miso_oe    <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_sample_edge) begin
                        r_shift_in <= w_rx_word;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_rx_data  <= w_rx_word;
                            r_rx_valid <= 1'b1;
`ifdef SPI_SLAVE_BURST_EN
                            r_bit_cnt <= '0;
                            r_reload  <= 1'b1;
`else
                            r_bit_cnt <= FULL_CNT;
                            r_miso_oe <= 1'b0;
                            r_state   <= DONE;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_shift_edge) begin
                        if (r_reload) begin
                            if (r_hold_full) begin
                                r_shift_out <= r_hold;
                                r_hold_full <= 1'b0;
                            end else begin
                                r_shift_out   <= '0;
                                r_tx_underrun <= 1'b1;
                            end
                            r_reload <= 1'b0;
                        end else if (CPHA != 0 && r_first_edge) begin
                            r_first_edge <= 1'b0;
                        end else begin
                            r_shift_out <= {r_shift_out[WIDTH-2:0], 1'b0};
                        end
                    end

                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_miso_oe <= 1'b0;
                        if (!w_word_done && r_bit_cnt != '0)
                            r_frame_err <= 1'b1;
                    end
                end

                DONE: begin
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_miso_oe <= 1'b0;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign MISO        = r_shift_out[WIDTH-1];
    assign MISO_OE     = r_miso_oe;
    assign TX_READY    = ~r_hold_full;
    assign RX_DATA     = r_rx_data;
    assign RX_VALID    = r_rx_valid;
    assign TX_UNDERRUN = r_tx_underrun;
    assign FRAME_ERR   = r_frame_err;
    assign BUSY        = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: mode 0 and mode 3 instances driven by a bit-level SPI master.
module tb_spi_slave_sync;

    localparam int W = 16;
    localparam int H = 8;
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        sck[2], cs[2], mosi[2], tx_valid[2];
    logic [15:0] tx_data[2];
    logic        miso[2], miso_oe[2], tx_ready[2], rx_valid[2], tx_uf[2], ferr[2], busy[2];
    logic [15:0] rx_data[2];

    always #5 clk = ~clk;

    spi_slave_sync #(.WIDTH(W), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_dut0 (
        .CLK(clk), .RST(rst), .SCK(sck[0]), .CSbar(cs[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .MISO_OE(miso_oe[0]), .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]),
        .TX_READY(tx_ready[0]), .RX_DATA(rx_data[0]), .RX_VALID(rx_valid[0]),
        .TX_UNDERRUN(tx_uf[0]), .FRAME_ERR(ferr[0]), .BUSY(busy[0])
    );

    spi_slave_sync #(.WIDTH(W), .CPOL(1), .CPHA(1), .SYNC_STAGES(3)) u_dut3 (
        .CLK(clk), .RST(rst), .SCK(sck[1]), .CSbar(cs[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .MISO_OE(miso_oe[1]), .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]),
        .TX_READY(tx_ready[1]), .RX_DATA(rx_data[1]), .RX_VALID(rx_valid[1]),
        .TX_UNDERRUN(tx_uf[1]), .FRAME_ERR(ferr[1]), .BUSY(busy[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    // strobe monitors
    int   rxv_cnt[2]  = '{0, 0};
    int   uf_cnt[2]   = '{0, 0};
    int   fe_cnt[2]   = '{0, 0};
    int   wide_err[2] = '{0, 0};
    logic prev_rxv[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rx_valid[d]) rxv_cnt[d]++;
            if (rx_valid[d] && prev_rxv[d]) wide_err[d]++;
            prev_rxv[d] = rx_valid[d];
            if (tx_uf[d]) uf_cnt[d]++;
            if (ferr[d]) fe_cnt[d]++;
        end
    end

    // reference model: one-deep holding register and last received word per slave
    logic        m_full[2] = '{1'b0, 1'b0};
    logic [15:0] m_hold[2] = '{16'h0, 16'h0};
    logic [15:0] m_rx[2]   = '{16'h0, 16'h0};

    typedef struct {
        int          d;
        bit          tx_en;
        logic [15:0] tx;
        logic [15:0] mo;
        int          nbits;
        logic [15:0] exp_read;
        logic [15:0] exp_rx;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer_tx(input int d, input logic [15:0] w);
        int t;
        t = 0;
        while (!tx_ready[d] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_wait", tx_ready[d], 1);
        tx_data[d]  = w;
        tx_valid[d] = 1'b1;
        @(negedge clk);
        tx_valid[d] = 1'b0;
        chk("tx_ready_after_offer", tx_ready[d], 0);
        m_full[d] = 1'b1;
        m_hold[d] = w;
    endtask

    task automatic m_load(input int d, output logic [15:0] w, inout int uf);
        if (m_full[d]) begin
            w = m_hold[d];
            m_full[d] = 1'b0;
        end else begin
            w = 16'h0;
            uf++;
        end
    endtask

    // Bit-level master. Slave d=0 is mode 0, d=1 is mode 3 (CPOL=CPHA=1).
    task automatic xfer(input int d, input logic [31:0] mo, input int nbits,
                        input int mid_at, input logic [15:0] mid_w, input int rst_at,
                        output logic [31:0] mi, output logic oe_pre);
        logic pol;
        logic ph;
        pol = (d == 1);
        ph  = (d == 1);
        mi = '0;
        oe_pre = 1'b0;
        cs[d] = 1'b0;
        clks(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                cs[d] = 1'b1;
                sck[d] = pol;
                mosi[d] = 1'b0;
                clks(1);
                chk("rst_miso", miso[d], 0);
                chk("rst_miso_oe", miso_oe[d], 0);
                chk("rst_tx_ready", tx_ready[d], 1);
                chk("rst_rx_data", rx_data[d], 0);
                chk("rst_rx_valid", rx_valid[d], 0);
                chk("rst_busy", busy[d], 0);
                m_full[0] = 1'b0;
                m_full[1] = 1'b0;
                m_rx[0] = 16'h0;
                m_rx[1] = 16'h0;
                clks(2);
                rst = 1'b0;
                clks(H);
                return;
            end
            if (i == mid_at) begin
                tx_data[d]  = mid_w;
                tx_valid[d] = 1'b1;
                clks(1);
                tx_valid[d] = 1'b0;
                m_full[d] = 1'b1;
                m_hold[d] = mid_w;
            end
            if (!ph) begin
                mosi[d] = mo[nbits-1-i];
                clks(H);
                sck[d] = ~pol;
                mi = {mi[30:0], miso[d]};
                clks(H);
                sck[d] = pol;
            end else begin
                sck[d] = ~pol;
                mosi[d] = mo[nbits-1-i];
                clks(H);
                sck[d] = pol;
                mi = {mi[30:0], miso[d]};
                clks(H);
            end
        end
        clks(H);
        oe_pre = miso_oe[d];
        cs[d] = 1'b1;
        clks(H);
    endtask

    task automatic run_frame(input int d, input logic [31:0] mo, input int nbits,
                             input int mid_at, input logic [15:0] mid_w,
                             output logic [31:0] mi);
        logic [15:0] loads[$];
        logic [15:0] w;
        logic [31:0] exp_mi;
        logic [31:0] tmp;
        logic        oe_pre;
        int uf_exp, nw, extra, rxv0, uf0, fe0, wide0;
        uf_exp = 0;
        rxv0 = rxv_cnt[d];
        uf0 = uf_cnt[d];
        fe0 = fe_cnt[d];
        wide0 = wide_err[d];
        m_load(d, w, uf_exp);
        loads.push_back(w);
        xfer(d, mo, nbits, mid_at, mid_w, -1, mi, oe_pre);
        nw = nbits / W;
        extra = 0;
        // in burst mode each completed word is followed by a reload on the next shift edge
        if (BURST) extra = (d == 0) ? nw : ((nbits - 1) / W);
        for (int k = 0; k < extra; k++) begin
            m_load(d, w, uf_exp);
            loads.push_back(w);
        end
        exp_mi = '0;
        for (int i = 0; i < nbits; i++) begin
            w = loads[i / W];
            exp_mi = {exp_mi[30:0], w[W-1-(i % W)]};
        end
        if (nw > 0) begin
            tmp = mo >> (nbits - W * nw);
            m_rx[d] = tmp[15:0];
        end
        chk("miso_bits", mi, exp_mi);
        chk("rx_data", rx_data[d], m_rx[d]);
        chk("rx_valid_count", rxv_cnt[d] - rxv0, nw);
        chk("rx_valid_width", wide_err[d] - wide0, 0);
        chk("underrun_count", uf_cnt[d] - uf0, uf_exp);
        chk("frame_err_count", fe_cnt[d] - fe0, (nbits % W != 0));
        chk("oe_before_cs_rise", oe_pre, (BURST || (nbits % W != 0)) ? 1 : 0);
        chk("oe_after_cs_rise", miso_oe[d], 0);
        chk("busy_idle", busy[d], 0);
        chk("tx_ready_idle", tx_ready[d], !m_full[d]);
    endtask

    vec_t        vt[6];
    logic [31:0] mi;
    logic        oe_dummy;
    int          d, nb, rxv0, fe0;

    initial begin
        vt[0] = '{0, 1'b1, 16'hA001, 16'h5AC3, 16, 16'hA001, 16'h5AC3};
        vt[1] = '{1, 1'b1, 16'h1234, 16'hFFFF, 16, 16'h1234, 16'hFFFF};
        vt[2] = '{0, 1'b0, 16'h0000, 16'h0F0F, 16, 16'h0000, 16'h0F0F};
        vt[3] = '{1, 1'b0, 16'h0000, 16'h8001, 16, 16'h0000, 16'h8001};
        vt[4] = '{0, 1'b1, 16'h3C5A, 16'h7FFF,  7, 16'h001E, 16'h0F0F};
        vt[5] = '{0, 1'b1, 16'hBEEF, 16'h1357, 16, 16'hBEEF, 16'h1357};

        cs[0] = 1'b1; cs[1] = 1'b1;
        sck[0] = 1'b0; sck[1] = 1'b1;
        mosi[0] = 1'b0; mosi[1] = 1'b0;
        tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
        tx_data[0] = 16'h0; tx_data[1] = 16'h0;
        rst = 1'b1;
        clks(4);
        for (int k = 0; k < 2; k++) begin
            chk("reset_miso", miso[k], 0);
            chk("reset_miso_oe", miso_oe[k], 0);
            chk("reset_tx_ready", tx_ready[k], 1);
            chk("reset_rx_data", rx_data[k], 0);
            chk("reset_rx_valid", rx_valid[k], 0);
            chk("reset_underrun", tx_uf[k], 0);
            chk("reset_frame_err", ferr[k], 0);
            chk("reset_busy", busy[k], 0);
        end
        rst = 1'b0;
        clks(4);

        foreach (vt[i]) begin
            if (vt[i].tx_en) offer_tx(vt[i].d, vt[i].tx);
            run_frame(vt[i].d, {16'h0, vt[i].mo}, vt[i].nbits, -1, 16'h0, mi);
            chk("vec_read", mi[15:0], vt[i].exp_read);
            chk("vec_rx", rx_data[vt[i].d], vt[i].exp_rx);
        end

`ifdef SPI_SLAVE_BURST_EN
        offer_tx(0, 16'hA001);
        run_frame(0, 32'h5AC3_9E01, 32, 4, 16'hA002, mi);
        chk("burst_read", mi, 32'hA001_A002);
`endif

        // reset in the middle of bit 9, then a clean frame
        offer_tx(0, 16'h1111);
        rxv0 = rxv_cnt[0];
        fe0 = fe_cnt[0];
        xfer(0, 32'h0000_ABCD, 16, -1, 16'h0, 9, mi, oe_dummy);
        chk("rst_no_rx_valid", rxv_cnt[0] - rxv0, 0);
        chk("rst_no_frame_err", fe_cnt[0] - fe0, 0);
        offer_tx(0, 16'hC0DE);
        run_frame(0, 32'h0000_6B2D, 16, -1, 16'h0, mi);
        chk("post_rst_read", mi[15:0], 16'hC0DE);

        repeat (12) begin
            d = int'($urandom % 2);
            if (!m_full[d] && ($urandom % 3) != 0) offer_tx(d, 16'($urandom));
            nb = (($urandom % 4) == 0) ? int'(1 + $urandom % 15) : 16;
            run_frame(d, $urandom, nb, -1, 16'h0, mi);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
